// File: rtl/lab3_conv_pkg.sv
// Shared types for the serial Excess-3 to BCD converter: state encoding and word length.
package lab3_conv_pkg;

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4,
    S5 = 3'd5,
    S6 = 3'd6
  } state_t;

  localparam int WORD_LEN = 4;

endpackage

// File: rtl/lab3_converter_state_diagram.sv
// Serial Excess-3 to BCD converter (Mealy, LSB first, subtracts 0011 bit by bit).
// Optional macro CONV_CHECK_EN adds simulation-only checks on X and the state register.
//
// state | meaning
// S0    | bit0
// S1    | bit1, no borrow
// S2    | bit1, borrow
// S3    | bit2, no borrow
// S4    | bit2, borrow
// S5    | bit3, no borrow
// S6    | bit3, borrow
module lab3_converter_state_diagram
  import lab3_conv_pkg::*;
(
  input  logic Clk,
  input  logic Rst,
  input  logic X,
  output logic Z
);

  state_t state;
  state_t next_state;
  logic   z_raw;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= S0;
    else      state <= next_state;
  end

  always_comb begin
    next_state = S0;
    z_raw      = 1'b0;
    case (state)
      S0: begin
        next_state = X ? S1 : S2;
        z_raw      = ~X;
      end
      S1: begin
        next_state = X ? S3 : S4;
        z_raw      = ~X;
      end
      S2: begin
        next_state = S4;
        z_raw      = X;
      end
      S3: begin
        next_state = S5;
        z_raw      = X;
      end
      S4: begin
        next_state = X ? S5 : S6;
        z_raw      = ~X;
      end
      S5: begin
        next_state = S0;
        z_raw      = X;
      end
      S6: begin
        next_state = S0;
        z_raw      = ~X;
      end
      default: begin
        next_state = S0;
        z_raw      = 1'b0;
      end
    endcase
  end

  // Output is held low for the whole time reset is asserted.
  assign Z = Rst & z_raw;

`ifdef CONV_CHECK_EN
  always @(posedge Clk) begin
    if (Rst && $isunknown(X))
      $error("converter: X is unknown at rising edge");
    if ({state} == 3'b111)
      $error("converter: state register holds unused encoding");
  end
`else
`endif

endmodule

// File: tb/tb_lab3_converter_state_diagram.sv
// Self-checking bench for the serial Excess-3 to BCD converter.
module tb_lab3_converter_state_diagram;
  import lab3_conv_pkg::*;

  logic Clk;
  logic Rst;
  logic X;
  logic Z;

  int total = 0;
  int bad   = 0;

  // model state: bits of the current word seen so far
  int         idx = 0;
  logic [3:0] acc = 4'd0;

  lab3_converter_state_diagram dut (
    .Clk (Clk),
    .Rst (Rst),
    .X   (X),
    .Z   (Z)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Bit k of (value - 3) depends only on bits 0..k of value.
  function automatic logic model_z(input logic [3:0] a, input int k, input logic x);
    logic [3:0] v;
    v = a | (4'(x) << k);
    v = v - 4'd3;
    return v[k];
  endfunction

  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      idx = 0;
      acc = 4'd0;
    end else begin
      acc = acc | (4'(X) << idx);
      idx = idx + 1;
      if (idx == WORD_LEN) begin
        idx = 0;
        acc = 4'd0;
      end
    end
  end

  always @(negedge Clk) begin
    logic e;
    e = Rst ? model_z(acc, idx, X) : 1'b0;
    total++;
    if (Z !== e) begin
      bad++;
      $display("FAIL z_cycle t=%0t idx=%0d x=%b got=%b want=%b", $time, idx, X, Z, e);
    end
  end

  task automatic check4(input string name, input logic [3:0] got, input logic [3:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%b want=%b", name, got, want);
    end
  endtask

  // Called just after a rising edge; leaves time just after a rising edge.
  task automatic shift_word(input logic [3:0] w, output logic [3:0] z);
    for (int i = 0; i < WORD_LEN; i++) begin
      X = w[i];
      @(negedge Clk);
      z[i] = Z;
      @(posedge Clk);
      #2;
    end
  endtask

  task automatic do_reset();
    @(posedge Clk);
    #2;
    Rst = 1'b0;
    X   = 1'($urandom);
    @(posedge Clk);
    #2;
    Rst = 1'b1;
  endtask

  initial begin
    logic [3:0] z, z2;
    logic [3:0] exp_tab [10];
    exp_tab = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
                4'b0101, 4'b0110, 4'b0111, 4'b1000, 4'b1001};

    Rst = 1'b0;
    X   = 1'b1;
    #3;
    total++;
    if (Z !== 1'b0) begin
      bad++;
      $display("FAIL reset_z got=%b want=0", Z);
    end

    @(posedge Clk);
    #2;
    Rst = 1'b1;
    X   = 1'b1;
    #1;
    total++;
    if (Z !== 1'b0) begin
      bad++;
      $display("FAIL release_x1 got=%b want=0", Z);
    end

    for (int d = 0; d < 10; d++) begin
      logic [3:0] w;
      w = 4'(d + 3);
      do_reset();
      shift_word(w, z);
      check4($sformatf("digit_%0d", d), z, exp_tab[d]);
    end

    do_reset();
    shift_word(4'b1000, z);
    shift_word(4'b1100, z2);
    check4("b2b_first", z, 4'b0101);
    check4("b2b_second", z2, 4'b1001);

    // mid-word async reset: two bits of 0101, then a pulse between edges
    do_reset();
    X = 1'b1;
    @(posedge Clk);
    #2;
    X = 1'b0;
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    #1;
    Rst = 1'b1;
    shift_word(4'b0111, z);
    check4("mid_reset", z, 4'b0100);

    do_reset();
    shift_word(4'b1111, z);
    check4("invalid_1111", z, 4'b1100);
    do_reset();
    shift_word(4'b0000, z);
    check4("invalid_0000", z, 4'b1101);

    // random streaming with occasional async resets, checked every cycle
    for (int n = 0; n < 400; n++) begin
      X = 1'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        #1;
        Rst = 1'b0;
        #1;
        Rst = 1'b1;
      end else if ($urandom_range(0, 31) == 0) begin
        Rst = 1'b0;
        @(posedge Clk);
        #2;
        Rst = 1'b1;
        X = 1'($urandom);
      end
      @(posedge Clk);
      #2;
    end

    @(posedge Clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
